acc_reduce: RTL and testbench
=============================

# acc_reduce

Windowed accumulator stage that consumes the ready/data stream of the MUL operator and reduces it. It sums a fixed number of valid products into one result and emits that sum as a single-cycle valid token, which gives a dot-product or MAC reduction behind the multiplier. It uses the same CLK/RST/EN/R/D dataflow convention as the other operators, so its output can feed any N-bit operator downstream.

## Interface
- N, 16: data width of input and output; unsigned
- WIN, 4: products per window; legal range 2..256
- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset, synchronous, active-high
- EN  in  1  stage enable; when low, all state and outputs hold
- R_IN  in  1  input token valid, usually MUL R_OUT
- D_IN  in  N  input product, usually MUL D_OUT
- FLUSH  in  1  close the current window early and emit the partial sum
- R_OUT  out  1  result valid, registered
- D_OUT  out  N  result sum, saturated to N bits, registered
- OVF  out  1  set when the emitted sum exceeded 2^N-1; qualified by R_OUT

## Operation
- Internal accumulator ACC is N+clog2(WIN) bits wide, so it cannot overflow inside one window.
- Element counter CNT is clog2(WIN) bits and counts 0..WIN-1.
- State machine:
  - EMPTY: CNT=0, ACC=0.
  - ACCUM: at least one element held.
- With EN=1, at each posedge:
  - R_IN=1 and CNT<WIN-1 and FLUSH=0: ACC += D_IN; CNT++; state becomes ACCUM; R_OUT <= 0.
  - R_IN=1 and CNT==WIN-1 (window complete): emit sat(ACC+D_IN); ACC <= 0; CNT <= 0; state becomes EMPTY.
  - FLUSH=1 in ACCUM: emit sat(ACC + (R_IN ? D_IN : 0)); the D_IN of that cycle is included; ACC and CNT clear; state becomes EMPTY.
  - FLUSH=1 in EMPTY with R_IN=1: emit D_IN as a one-element window.
  - FLUSH=1 in EMPTY with R_IN=0: no emission; R_OUT <= 0.
  - Any other cycle: R_OUT <= 0; D_OUT and OVF hold.
- Emit means R_OUT <= 1, D_OUT <= sum clipped to 2^N-1, and OVF <= (sum > 2^N-1).
- EN=0: ACC, CNT, state, R_OUT, D_OUT and OVF all hold. A held R_OUT=1 stays asserted, matching the other operators; downstream gates on its own EN.
- RST, which has priority over EN: R_OUT=0, D_OUT=0, OVF=0, ACC=0, CNT=0, state EMPTY. A reset in the middle of a window discards the partial sum and emits nothing.
- Input tokens are never back-pressured. Every token with R_IN=1 and EN=1 is consumed in that cycle.

## Timing
- Latency is 1 cycle: the result is visible after the posedge that consumes the WIN-th token, or after the FLUSH edge.
- Back-to-back windows need no bubble. The token in the cycle after an emission is element 0 of the next window.
- At most one R_OUT pulse per emission. With continuous input, R_OUT is high for 1 cycle in every WIN.
- OVF is valid only when R_OUT=1. Its value is don't-care otherwise, but it holds its last value.
- No combinational path from any input to any output.

## Structure
- The shared dataflow package holds:
  - the N default;
  - an ACC_W(N,WIN) = N+clog2(WIN) constant function;
  - a SAT_MAX(N) constant.
- Sub-module acc_sat is combinational: it takes an ACC_W-bit sum and produces an N-bit saturated value plus an overflow bit. It is reused by other saturating operators.
- acc_reduce holds the FSM, CNT, ACC and the output registers.

## Test plan
- N=16, WIN=4, EN=1; R_IN=1 with D_IN 1,2,3,4 on consecutive cycles -> R_OUT=1 for exactly 1 cycle after the 4th edge with D_OUT=10 and OVF=0; R_OUT=0 otherwise.
- Continuous R_IN=1 for 8 cycles, D_IN=100 each -> two R_OUT pulses 4 cycles apart, each with D_OUT=400, and no gap between windows.
- D_IN 0xFFFF, 0xFFFF, 1, 0 -> D_OUT=0xFFFF, OVF=1. The next window 1,1,1,1 -> D_OUT=4, OVF=0.
- Tokens 5 and 6, then FLUSH=1 with R_IN=1 and D_IN=7 -> D_OUT=18. Then FLUSH=1 alone in EMPTY -> no R_OUT pulse.
- Tokens 1 and 2, then EN=0 for 3 cycles with R_IN=1 and D_IN=99, then EN=1 with tokens 3 and 4 -> D_OUT=10, and the 99s are ignored.
- Tokens 9 and 9, then RST for 1 cycle, then tokens 1,1,1,1 -> no emission for the 9s; the single result is D_OUT=4; all outputs read 0 in the cycle after RST.

Source files
------------

// File: rtl/acc_reduce_pkg.sv
// Shared dataflow definitions for the R/D operator family: default width,
// accumulator sizing and the saturation ceiling.
package acc_reduce_pkg;

  localparam int unsigned N_DEFAULT = 16;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  // Width that holds WIN products of N bits without wrapping.
  function automatic int unsigned ACC_W(input int unsigned n, input int unsigned win);
    return n + unsigned'($clog2(win));
  endfunction

  function automatic logic [63:0] SAT_MAX(input int unsigned n);
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/acc_reduce_if.sv
// Product stream in, reduced result stream out; master is the producer side.
interface acc_reduce_if
  import acc_reduce_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
);
  logic         R_IN;
  logic [N-1:0] D_IN;
  logic         FLUSH;
  logic         R_OUT;
  logic [N-1:0] D_OUT;
  logic         OVF;

  modport master (
    output R_IN, D_IN, FLUSH,
    input  R_OUT, D_OUT, OVF
  );

  modport slave (
    input  R_IN, D_IN, FLUSH,
    output R_OUT, D_OUT, OVF
  );
endinterface

// File: rtl/acc_sat.sv
// Clips a wide unsigned sum to N bits and flags whether clipping happened.
module acc_sat
  import acc_reduce_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned W = N + 1
) (
  input  logic [W-1:0] sum_i,
  output logic [N-1:0] sat_o,
  output logic         ovf_o
);

  // Any bit above N means the sum does not fit.
  always_comb begin
    ovf_o = |sum_i[W-1:N];
    if (ovf_o) begin
      sat_o = N'(SAT_MAX(N));
    end else begin
      sat_o = sum_i[N-1:0];
    end
  end

endmodule

// File: rtl/acc_reduce.sv
// Windowed accumulator: sums WIN valid products (or fewer on FLUSH) and emits
// the saturated total as a one-cycle R_OUT token.
module acc_reduce
  import acc_reduce_pkg::*;
#(
  parameter int unsigned N   = N_DEFAULT,
  parameter int unsigned WIN = 4
) (
  input logic         CLK,
  input logic         RST,
  input logic         EN,
  acc_reduce_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(WIN);
  localparam int unsigned      SUM_W    = ACC_W(N, WIN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

  acc_state_e       state_q;
  logic [SUM_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             r_out_q;
  logic [N-1:0]     d_out_q;
  logic             ovf_q;

  logic [SUM_W-1:0] sum_d;
  logic [N-1:0]     sat_d;
  logic             ovf_d;
  logic             emit_d;

  // Running total including this cycle's product, if one is present.
  always_comb begin
    if (bus.R_IN) begin
      sum_d = acc_q + SUM_W'(bus.D_IN);
    end else begin
      sum_d = acc_q;
    end
  end

  acc_sat #(
    .N (N),
    .W (SUM_W)
  ) u_sat (
    .sum_i (sum_d),
    .sat_o (sat_d),
    .ovf_o (ovf_d)
  );

  // A FLUSH with nothing held and no token this cycle has nothing to emit.
  assign emit_d = (bus.R_IN && (cnt_q == CNT_LAST)) ||
                  (bus.FLUSH && ((state_q == ST_ACCUM) || bus.R_IN));

  // Window FSM, counters and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      r_out_q <= 1'b0;
      d_out_q <= '0;
      ovf_q   <= 1'b0;
    end else if (EN) begin
      if (emit_d) begin
        r_out_q <= 1'b1;
        d_out_q <= sat_d;
        ovf_q   <= ovf_d;
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= ST_EMPTY;
      end else begin
        r_out_q <= 1'b0;
        if (bus.R_IN) begin
          acc_q   <= sum_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= ST_ACCUM;
        end
      end
    end
  end

  assign bus.R_OUT = r_out_q;
  assign bus.D_OUT = d_out_q;
  assign bus.OVF   = ovf_q;

endmodule

// File: tb/tb_acc_reduce.sv
// Scoreboard bench for acc_reduce (N=16, WIN=4): expected results are queued
// with the cycle they must appear in and matched against every R_OUT pulse.
module tb_acc_reduce;

  typedef struct {
    logic [15:0] d;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic EN  = 1'b0;
  int   cyc = 0;
  logic en_q = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  acc_reduce_if #(.N(16)) bus ();

  acc_reduce #(.N(16), .WIN(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc  <= cyc + 1;
    en_q <= EN;
  end

  // Every fresh R_OUT pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (bus.R_OUT === 1'b1 && en_q === 1'b1) begin
      n_checks = n_checks + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_rout: R_OUT=1 at cycle %0d with D_OUT=%0h, none expected", cyc, bus.D_OUT);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL rout_cycle: got cycle %0d expected cycle %0d", cyc, e.cyc);
        end
        n_checks = n_checks + 1;
        if (bus.D_OUT !== e.d) begin
          n_fail = n_fail + 1;
          $display("FAIL d_out: got %0h expected %0h (cycle %0d)", bus.D_OUT, e.d, cyc);
        end
        n_checks = n_checks + 1;
        if (bus.OVF !== e.ovf) begin
          n_fail = n_fail + 1;
          $display("FAIL ovf: got %0b expected %0b (cycle %0d)", bus.OVF, e.ovf, cyc);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [15:0] d, input logic fl, input logic e);
    bus.R_IN  = r;
    bus.D_IN  = d;
    bus.FLUSH = fl;
    EN        = e;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_next(input logic [15:0] d, input logic ovf);
    sb.push_back('{d, ovf, cyc + 1});
  endtask

  task automatic settle(input string name);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    n_checks = n_checks + 1;
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_missing: %0d expected results never appeared", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    RST = 1'b0;
    n_checks = n_checks + 3;
    if (bus.R_OUT !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_rout: got %0b expected 0", bus.R_OUT);
    end
    if (bus.D_OUT !== 16'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_dout: got %0h expected 0", bus.D_OUT);
    end
    if (bus.OVF !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_ovf: got %0b expected 0", bus.OVF);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 16'd1, 1'b0, 1'b1);
    drive(1'b1, 16'd2, 1'b0, 1'b1);
    drive(1'b1, 16'd3, 1'b0, 1'b1);
    expect_next(16'd10, 1'b0);
    drive(1'b1, 16'd4, 1'b0, 1'b1);
    settle("basic");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) expect_next(16'd400, 1'b0);
      drive(1'b1, 16'd100, 1'b0, 1'b1);
    end
    settle("back_to_back");
  endtask

  task automatic test_saturation();
    logic [15:0] vals [8];
    vals = '{16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
    for (int i = 0; i < 8; i++) begin
      if (i == 3) expect_next(16'hFFFF, 1'b1);
      if (i == 7) expect_next(16'd4, 1'b0);
      drive(1'b1, vals[i], 1'b0, 1'b1);
    end
    settle("saturation");
  endtask

  task automatic test_flush();
    drive(1'b1, 16'd5, 1'b0, 1'b1);
    drive(1'b1, 16'd6, 1'b0, 1'b1);
    expect_next(16'd18, 1'b0);
    drive(1'b1, 16'd7, 1'b1, 1'b1);
    drive(1'b0, 16'd0, 1'b1, 1'b1);
    n_checks = n_checks + 1;
    if (bus.R_OUT !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL flush_empty: got R_OUT=%0b expected 0", bus.R_OUT);
    end
    expect_next(16'd42, 1'b0);
    drive(1'b1, 16'd42, 1'b1, 1'b1);
    drive(1'b1, 16'd3, 1'b0, 1'b1);
    expect_next(16'd3, 1'b0);
    drive(1'b0, 16'd0, 1'b1, 1'b1);
    settle("flush");
  endtask

  task automatic test_enable();
    drive(1'b1, 16'd1, 1'b0, 1'b1);
    drive(1'b1, 16'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'd99, 1'b0, 1'b0);
      n_checks = n_checks + 1;
      if (bus.R_OUT !== 1'b0 || bus.D_OUT !== 16'd3) begin
        n_fail = n_fail + 1;
        $display("FAIL enable_hold: got R_OUT=%0b D_OUT=%0h expected R_OUT=0 D_OUT=3", bus.R_OUT, bus.D_OUT);
      end
    end
    drive(1'b1, 16'd3, 1'b0, 1'b1);
    expect_next(16'd10, 1'b0);
    drive(1'b1, 16'd4, 1'b0, 1'b1);
    settle("enable");
  endtask

  task automatic test_rst_mid();
    drive(1'b1, 16'd9, 1'b0, 1'b1);
    drive(1'b1, 16'd9, 1'b0, 1'b1);
    RST = 1'b1;
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    RST = 1'b0;
    n_checks = n_checks + 1;
    if (bus.R_OUT !== 1'b0 || bus.D_OUT !== 16'd0 || bus.OVF !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL rst_mid_outputs: got R_OUT=%0b D_OUT=%0h OVF=%0b expected all 0", bus.R_OUT, bus.D_OUT, bus.OVF);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect_next(16'd4, 1'b0);
      drive(1'b1, 16'd1, 1'b0, 1'b1);
    end
    settle("rst_mid");
  endtask

  initial begin
    bus.R_IN  = 1'b0;
    bus.D_IN  = 16'd0;
    bus.FLUSH = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_flush();
    test_enable();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
